// File: rtl/barcode_pkg.sv
// Shared types for the barcode receiver: FSM state encoding and index-width helper.
package barcode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEAS,
        WAIT_FALL,
        SAMPLE,
        DONE
    } state_t;

    function automatic int idx_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/bc_sync_edge.sv
// Two-flop synchroniser for the barcode line plus fall/rise detection.
// All flops reset to 1 so an idle-high line produces no spurious edge.
module bc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic bc,
    output logic bc_s,
    output logic fall,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = bc;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign bc_s = s2_q;
    assign fall = s3_q & ~s2_q;
    assign rise = ~s3_q & s2_q;

endmodule

// File: rtl/barcode_rx.sv
// Self-clocked barcode receiver: the start bit's low time sets the bit period T,
// each data bit is sampled T cycles after its falling edge.
module barcode_rx
    import barcode_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PREFIX_W = 2,
    parameter int CNT_W    = 22,
    parameter int MIN_T    = 16,
    parameter int TO_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BC,
    input  logic              clr_ID_vld,
    output logic [DATA_W-1:0] ID,
    output logic              ID_vld,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = idx_w(DATA_W);
    localparam int GAP_W = CNT_W + TO_SHIFT;

    logic bc_s, fall, rise;

    bc_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .bc   (BC),
        .bc_s (bc_s),
        .fall (fall),
        .rise (rise)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   t_q, t_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]  id_q, id_d;
    logic               id_vld_q, id_vld_d;
    logic               err_q, err_d;
    logic [GAP_W-1:0]   to_lim;
    logic               prefix_ok;

    // Timeout limit kept at full width so large periods are not truncated.
    assign to_lim = GAP_W'(t_q) << TO_SHIFT;

    always_comb begin
        prefix_ok = 1'b1;
        for (int i = 0; i < PREFIX_W; i++) begin
            if (shreg_q[DATA_W-1-i]) prefix_ok = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        gap_d     = gap_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        id_d      = id_q;
        id_vld_d  = id_vld_q & ~clr_ID_vld;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = MEAS;
                    cnt_d   = '0;
                end
            end
            MEAS: begin
                if (rise) begin
                    if (cnt_q < CNT_W'(MIN_T)) begin
                        state_d = IDLE;
                    end else begin
                        t_d       = cnt_q;
                        bit_idx_d = '0;
                        gap_d     = '0;
                        state_d   = WAIT_FALL;
                    end
                end else if (&cnt_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else if (gap_q > to_lim) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == t_q) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], bc_s};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_FALL;
                        gap_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                // A valid frame's set overrides a simultaneous consumer clear.
                if (prefix_ok) begin
                    id_d     = shreg_q;
                    id_vld_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            t_q       <= '0;
            gap_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            gap_q     <= gap_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
            err_q     <= err_d;
        end
    end

    assign ID     = id_q;
    assign ID_vld = id_vld_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);

endmodule
